// File: rtl/pwm_multi.sv
// Multi-channel double-buffered PWM generator: one shared edge/center-aligned
// counter, staged settings promoted to the active set only at period boundaries.
module pwm_multi #(
  parameter int unsigned nbits = 16,
  parameter int unsigned nch   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [nbits-1:0]     period,
  input  logic                 mode,
  input  logic [nch*nbits-1:0] duty,
  input  logic                 load,
  output logic [nch-1:0]       out,
  output logic                 cycle_start,
  output logic                 pending
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  localparam logic [nbits-1:0] one = nbits'(1);

  logic [nbits-1:0]     stg_period, act_period;
  logic                 stg_mode, act_mode;
  logic [nch*nbits-1:0] stg_duty, act_duty;
  logic [nbits-1:0]     cnt;
  dir_t                 dir;
  logic                 running;

  logic                 center;
  logic                 boundary;
  logic                 apply;
  logic [nch-1:0]       cmp;

  always_comb begin
    center   = act_mode && (act_period != '0);
    boundary = 1'b0;
    // With P==1 in center mode the up-count peak is also the last cycle of the period.
    if (center)
      boundary = (cnt == one) && ((dir == DOWN) || (cnt == act_period));
    else
      boundary = (cnt == act_period);
    apply = pending && (!en || (running && boundary));
  end

  always_comb begin
    cmp = '0;
    for (int unsigned i = 0; i < nch; i++)
      cmp[i] = cnt < act_duty[i*nbits +: nbits];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stg_period  <= '0;
      stg_mode    <= 1'b0;
      stg_duty    <= '0;
      act_period  <= '0;
      act_mode    <= 1'b0;
      act_duty    <= '0;
      cnt         <= '0;
      dir         <= UP;
      running     <= 1'b0;
      out         <= '0;
      cycle_start <= 1'b0;
      pending     <= 1'b0;
    end else begin
      running <= en;

      if (apply) begin
        act_period <= stg_period;
        act_mode   <= stg_mode;
        act_duty   <= stg_duty;
      end

      if (load) begin
        stg_period <= period;
        stg_mode   <= mode;
        stg_duty   <= duty;
        pending    <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end

      if (!en) begin
        cnt         <= '0;
        dir         <= UP;
        out         <= '0;
        cycle_start <= 1'b0;
      end else if (!running || boundary) begin
        // First enabled cycle restarts like a boundary but has no valid compare yet.
        cnt         <= '0;
        dir         <= UP;
        cycle_start <= 1'b1;
        out         <= running ? cmp : '0;
      end else begin
        cycle_start <= 1'b0;
        out         <= cmp;
        if (center) begin
          if (dir == UP) begin
            if (cnt == act_period) begin
              dir <= DOWN;
              cnt <= cnt - one;
            end else begin
              cnt <= cnt + one;
            end
          end else begin
            cnt <= cnt - one;
          end
        end else begin
          cnt <= cnt + one;
        end
      end
    end
  end

endmodule
